// File: rtl/incr_share_arb.sv
// Round-robin arbiter sharing one registered add-constant unit between NREQ
// valid/ready requesters. Optional burst lock enabled by `define SHARE_ARB_LOCK_EN.
module incr_share_arb #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  parameter  int INC  = 1,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [IW-1:0]     rsp_id,
  input  logic              rsp_ready,
  input  logic [NREQ-1:0]   lock_req
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;

  logic            can_accept;
  logic            accept;
  logic            found;
  logic [IW-1:0]   sel;
  logic [IW:0]     scan_idx;
  logic            hold;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   ptr_inc;

  // A new op may start when idle, or when the current result is being consumed.
  assign can_accept = (state_q == IDLE) || rsp_ready;

  // Highest scan offset is visited first so the lane nearest rr_ptr wins.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NREQ)) scan_idx = scan_idx - (IW+1)'(NREQ);
      if (req_valid[scan_idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = scan_idx[IW-1:0];
      end
    end
  end

`ifdef SHARE_ARB_LOCK_EN
  logic            lock_vld_q, lock_vld_d;
  logic [IW-1:0]   lock_id_q, lock_id_d;

  assign hold    = lock_vld_q && lock_req[lock_id_q];
  assign gnt_vld = hold ? req_valid[lock_id_q] : found;
  assign gnt_idx = hold ? lock_id_q : sel;

  // Ownership is re-evaluated only at grant decisions; a dropped lock_req frees it.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (can_accept && !hold) begin
      lock_vld_d = accept && lock_req[gnt_idx];
      lock_id_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^lock_req;
  assign hold        = 1'b0;
  assign gnt_vld     = found;
  assign gnt_idx     = sel;
`endif

  assign accept  = can_accept && gnt_vld;
  assign ptr_inc = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_data_d  = req_data[gnt_idx*W +: W] + W'(INC);
      rsp_id_d    = gnt_idx;
      rsp_valid_d = 1'b1;
      state_d     = BUSY;
      if (!hold) rr_ptr_d = ptr_inc;
    end else if (state_q == BUSY && rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_incr_share_arb.sv
// Directed self-checking bench for incr_share_arb (NREQ=4, W=8, INC=1).
// Lock expectations switch on SHARE_ARB_LOCK_EN to match the build.
module tb_incr_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic [3:0]  lock_req;

  int nChecks = 0;
  int nFails  = 0;

  incr_share_arb #(.NREQ(4), .W(8), .INC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .lock_req  (lock_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkRsp(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, "_data"},  32'(rsp_data),  32'(d));
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
  endtask

  logic [1:0] streamIds [8];
  logic [1:0] lockIds   [5];

  initial begin
    streamIds = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
`ifdef SHARE_ARB_LOCK_EN
    lockIds = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd1};
`else
    lockIds = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
`endif

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    lock_req  = '0;
    tick();
    tick();
    chkRsp("reset", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 20; i++) begin
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_valid", 32'(rsp_valid), 32'h0);
      tick();
    end

    // Single request on lane 2
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h0041_0000;
    #1;
    chk("lane2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chkRsp("lane2_rsp", 1'b1, 8'h42, 2'd2);
    tick();
    chk("lane2_drain", 32'(rsp_valid), 32'h0);

    // All lanes streaming, rr_ptr starts at 3
    req_valid = 4'hF;
    req_data  = 32'h3525_1505;
    #1;
    chk("stream_ready", 32'(req_ready), 32'h8);
    for (int i = 0; i < 8; i++) begin
      tick();
      chkRsp("stream", 1'b1, 8'h06 + 8'(streamIds[i]) * 8'h10, streamIds[i]);
    end
    req_valid = '0;
    tick();
    chk("stream_drain", 32'(rsp_valid), 32'h0);

    // Wrap-around add with backpressure; lane 1 waits meanwhile
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = 32'h0000_00FF;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    req_data  = 32'h0000_7F00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chkRsp("wrap_hold", 1'b1, 8'h00, 2'd0);
      chk("wrap_hold_ready", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chkRsp("b2b_rsp", 1'b1, 8'h80, 2'd1);
    tick();
    chk("b2b_drain", 32'(rsp_valid), 32'h0);

    // Reset while busy
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = 32'h0041_0000;
    tick();
    chkRsp("busy_pre_rst", 1'b1, 8'h42, 2'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chkRsp("async_rst", 1'b0, 8'h00, 2'd0);
    tick();
    chkRsp("in_rst", 1'b0, 8'h00, 2'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h3525_1505;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    chk("post_rst_valid", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = '0;
    chkRsp("post_rst_rsp", 1'b1, 8'h06, 2'd0);
    tick();
    chk("post_rst_drain", 32'(rsp_valid), 32'h0);

    // Lanes 1 and 3 with lock request on lane 1 for the first three grants
    req_valid = 4'b1010;
    req_data  = 32'h6000_2000;
    lock_req  = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) lock_req = '0;
      tick();
      chkRsp("lock_seq", 1'b1, (lockIds[i] == 2'd1) ? 8'h21 : 8'h61, lockIds[i]);
    end
    req_valid = '0;
    tick();
    chk("lock_drain", 32'(rsp_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
